ddr_rd_arbiter: RTL and testbench

Two-port round-robin read arbiter sharing the single AXI4 read port of the DDR3 memory controller between two requesters (e.g. a display/DMA engine and a debug/test reader). Each requester issues a simple address+length burst request and receives the returned beats on a per-port stream. The block sits in the `axi_aclk` domain between the requesters and the DDR3 controller slave port. It allows one burst outstanding at a time and checks protocol.

---
 rtl/ddr_rd_arbiter_if.sv | 85 ++++++++
 rtl/ddr_rd_arbiter.sv | 146 ++++++++++++++
 tb/tb_ddr_rd_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_rd_arbiter_if.sv
// Bundle of requester ports, per-port read streams and the AXI4 read channels
// around the two-port DDR3 read arbiter. The arbiter takes the master view
// because it masters the AXI read port. Requesters and the memory controller
// together take the slave view.
interface ddr_rd_arbiter_if #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
);
    // Requester 0
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [7:0]        req0_len;
    logic              req0_ready;
    logic [DATA_W-1:0] rd0_data;
    logic              rd0_valid;
    logic              rd0_last;
    logic              rd0_err;
    logic              rd0_ready;

    // Requester 1
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [7:0]        req1_len;
    logic              req1_ready;
    logic [DATA_W-1:0] rd1_data;
    logic              rd1_valid;
    logic              rd1_last;
    logic              rd1_err;
    logic              rd1_ready;

    // AXI4 read address channel
    logic [ADDR_W-1:0] m_axi_araddr;
    logic [7:0]        m_axi_arlen;
    logic [2:0]        m_axi_arsize;
    logic [1:0]        m_axi_arburst;
    logic              m_axi_arid;
    logic              m_axi_arvalid;
    logic              m_axi_arready;

    // AXI4 read data channel
    logic [DATA_W-1:0] m_axi_rdata;
    logic [1:0]        m_axi_rresp;
    logic              m_axi_rlast;
    logic              m_axi_rid;
    logic              m_axi_rvalid;
    logic              m_axi_rready;

    // Sticky protocol flags
    logic              err_4k;
    logic              err_last;

    modport master (
        input  req0_valid, req0_addr, req0_len,
        output req0_ready,
        output rd0_data, rd0_valid, rd0_last, rd0_err,
        input  rd0_ready,
        input  req1_valid, req1_addr, req1_len,
        output req1_ready,
        output rd1_data, rd1_valid, rd1_last, rd1_err,
        input  rd1_ready,
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
        output m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid, m_axi_rvalid,
        output m_axi_rready,
        output err_4k, err_last
    );

    modport slave (
        output req0_valid, req0_addr, req0_len,
        input  req0_ready,
        input  rd0_data, rd0_valid, rd0_last, rd0_err,
        output rd0_ready,
        output req1_valid, req1_addr, req1_len,
        input  req1_ready,
        input  rd1_data, rd1_valid, rd1_last, rd1_err,
        output rd1_ready,
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arid,
        input  m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rid, m_axi_rvalid,
        input  m_axi_rready,
        input  err_4k, err_last
    );
endinterface

// File: rtl/ddr_rd_arbiter.sv
// Two-port round-robin read arbiter in front of the DDR3 controller AXI4 read
// port. One burst is outstanding at a time. The AR channel is fully registered.
// R beats are steered combinationally to the granted port. Two sticky flags
// record 4 KB crossings and RLAST/RID inconsistencies.
module ddr_rd_arbiter #(
    parameter int unsigned ADDR_W = 28,
    parameter int unsigned DATA_W = 128
) (
    input  logic             axi_aclk,
    input  logic             axi_aresetn,
    ddr_rd_arbiter_if.master bus
);

    localparam int unsigned       SIZE      = $clog2(DATA_W / 8);
    // Sub-beat address bits are dropped so every burst starts beat-aligned
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << SIZE) - 1);

    typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

    state_e            state_q;
    logic              grant_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic              arvalid_q;
    logic [1:0]        req_ready_q;
    logic [8:0]        beat_cnt_q;
    logic              err_4k_q;
    logic              err_last_q;

    logic              pick_valid;
    logic              pick_port;
    logic [ADDR_W-1:0] pick_addr;
    logic [7:0]        pick_len;
    logic [31:0]       burst_end;
    logic              cross_4k;

    logic              in_r;
    logic              sel_ready;
    logic              r_hs;
    logic              last_bad;

    // Round-robin pick among pending requests and 4 KB check on the winner
    always_comb begin
        pick_valid = bus.req0_valid || bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            pick_port = ~last_grant_q;
        end else begin
            pick_port = bus.req1_valid;
        end
        pick_addr = pick_port ? bus.req1_addr : bus.req0_addr;
        pick_len  = pick_port ? bus.req1_len : bus.req0_len;
        burst_end = 32'(pick_addr[11:0]) + ((32'(pick_len) + 32'd1) << SIZE);
        cross_4k  = burst_end > 32'd4096;
    end

    // R-channel steering and per-beat protocol check
    always_comb begin
        in_r      = (state_q == StR);
        sel_ready = grant_q ? bus.rd1_ready : bus.rd0_ready;
        r_hs      = in_r && bus.m_axi_rvalid && sel_ready;
        // RLAST must land exactly on beat len+1, and RID must name the granted port
        last_bad  = (bus.m_axi_rlast != (beat_cnt_q == {1'b0, len_q}))
                    || (bus.m_axi_rid != grant_q);
    end

    // Arbitration FSM with registered AR channel, request acks and error flags
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            len_q        <= '0;
            arvalid_q    <= 1'b0;
            req_ready_q  <= 2'b00;
            beat_cnt_q   <= '0;
            err_4k_q     <= 1'b0;
            err_last_q   <= 1'b0;
        end else begin
            req_ready_q <= 2'b00;
            case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        grant_q      <= pick_port;
                        last_grant_q <= pick_port;
                        addr_q       <= pick_addr & ADDR_MASK;
                        len_q        <= pick_len;
                        arvalid_q    <= 1'b1;
                        if (cross_4k) begin
                            err_4k_q <= 1'b1;
                        end
                        state_q      <= StAr;
                    end
                end
                StAr: begin
                    if (bus.m_axi_arready) begin
                        arvalid_q            <= 1'b0;
                        req_ready_q[grant_q] <= 1'b1;
                        beat_cnt_q           <= '0;
                        state_q              <= StR;
                    end
                end
                StR: begin
                    if (r_hs) begin
                        beat_cnt_q <= beat_cnt_q + 9'd1;
                        if (last_bad) begin
                            err_last_q <= 1'b1;
                        end
                        if (bus.m_axi_rlast) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.m_axi_araddr  = addr_q;
    assign bus.m_axi_arlen   = len_q;
    assign bus.m_axi_arsize  = 3'(SIZE);
    assign bus.m_axi_arburst = 2'b01;
    assign bus.m_axi_arid    = grant_q;
    assign bus.m_axi_arvalid = arvalid_q;

    assign bus.req0_ready    = req_ready_q[0];
    assign bus.req1_ready    = req_ready_q[1];

    // Data fans out to both ports. Only the granted port sees valid/last/err.
    assign bus.rd0_data      = bus.m_axi_rdata;
    assign bus.rd1_data      = bus.m_axi_rdata;
    assign bus.rd0_valid     = in_r && !grant_q && bus.m_axi_rvalid;
    assign bus.rd1_valid     = in_r && grant_q && bus.m_axi_rvalid;
    assign bus.rd0_last      = in_r && !grant_q && bus.m_axi_rlast;
    assign bus.rd1_last      = in_r && grant_q && bus.m_axi_rlast;
    assign bus.rd0_err       = in_r && !grant_q && (bus.m_axi_rresp != 2'b00);
    assign bus.rd1_err       = in_r && grant_q && (bus.m_axi_rresp != 2'b00);
    assign bus.m_axi_rready  = in_r && sel_ready;

    assign bus.err_4k        = err_4k_q;
    assign bus.err_last      = err_last_q;

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Scoreboard bench for ddr_rd_arbiter: requests push expected AR fields and
// beats; a slave model answers the AR channel; a negedge monitor pops and
// compares.
module tb_ddr_rd_arbiter;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned DATA_W = 128;

    typedef struct {
        logic [27:0] addr;
        logic [7:0]  len;
        logic        id;
    } ar_t;

    typedef struct {
        logic         port;
        logic [127:0] data;
        logic         last;
        logic         err;
    } beat_t;

    logic clk;
    logic rst_n;

    ddr_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ddr_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .bus         (bus)
    );

    int    n_tests = 0;
    int    n_fail = 0;
    int    beats_seen = 0;
    ar_t   exp_ar[$];
    beat_t exp_beats[$];

    // Slave behaviour knobs
    int    ar_stall = 0;
    int    err_beat = -1;
    int    last_at = -1;
    bit    ar_idle_ready = 1'b1;
    bit    rd_toggle = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] beat_data(input logic [27:0] addr, input int i);
        return {36'h0, addr, 32'hC0DE_0000, 32'(i)};
    endfunction

    function automatic logic ready_of(input logic port);
        return port ? bus.req1_ready : bus.req0_ready;
    endfunction

    task automatic expect_burst(input logic port, input logic [27:0] addr, input logic [7:0] len);
        logic [27:0] m;
        int          n;
        m = addr & 28'hFFF_FFF0;
        exp_ar.push_back('{addr: m, len: len, id: port});
        n = (last_at >= 0) ? last_at : int'(len);
        for (int i = 0; i <= n; i++) begin
            exp_beats.push_back('{port: port, data: beat_data(m, i), last: (i == n),
                                  err: (i == err_beat)});
        end
    endtask

    // Drive a request and hold it until the ready pulse; lat counts cycles after the first one
    task automatic request(input logic port, input logic [27:0] addr, input logic [7:0] len,
                           input bit hold, output int lat);
        if (port) begin
            bus.req1_valid = 1'b1;
            bus.req1_addr  = addr;
            bus.req1_len   = len;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_addr  = addr;
            bus.req0_len   = len;
        end
        lat = 0;
        forever begin
            @(negedge clk);
            if (ready_of(port)) break;
            lat++;
            if (lat > 400) begin
                check_eq("req_timeout", 128'(lat), 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            if (port) bus.req1_valid = 1'b0;
            else bus.req0_valid = 1'b0;
        end
        check_eq("req_ready_pulse", ready_of(port), 1'b0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_beats.size() != 0 || exp_ar.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check_eq("drain", 128'(exp_beats.size() + exp_ar.size()), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string p);
        check_eq({p, "_req0_ready"}, bus.req0_ready, 1'b0);
        check_eq({p, "_req1_ready"}, bus.req1_ready, 1'b0);
        check_eq({p, "_rd0_valid"}, bus.rd0_valid, 1'b0);
        check_eq({p, "_rd1_valid"}, bus.rd1_valid, 1'b0);
        check_eq({p, "_rd0_last"}, bus.rd0_last, 1'b0);
        check_eq({p, "_rd1_last"}, bus.rd1_last, 1'b0);
        check_eq({p, "_rd0_err"}, bus.rd0_err, 1'b0);
        check_eq({p, "_rd1_err"}, bus.rd1_err, 1'b0);
        check_eq({p, "_arvalid"}, bus.m_axi_arvalid, 1'b0);
        check_eq({p, "_rready"}, bus.m_axi_rready, 1'b0);
        check_eq({p, "_araddr"}, bus.m_axi_araddr, 28'h0);
        check_eq({p, "_arlen"}, bus.m_axi_arlen, 8'h0);
        check_eq({p, "_arid"}, bus.m_axi_arid, 1'b0);
        check_eq({p, "_arsize"}, bus.m_axi_arsize, 3'd4);
        check_eq({p, "_arburst"}, bus.m_axi_arburst, 2'b01);
        check_eq({p, "_err_4k"}, bus.err_4k, 1'b0);
        check_eq({p, "_err_last"}, bus.err_last, 1'b0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_reset_values("rst");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input logic port, input logic [127:0] data, input logic last,
                              input logic err);
        beat_t e;
        if (exp_beats.size() == 0) begin
            check_eq("beat_pending", 128'(exp_beats.size()), 1);
        end else begin
            e = exp_beats.pop_front();
            check_eq("beat_port", port, e.port);
            check_eq("beat_data", data, e.data);
            check_eq("beat_last", last, e.last);
            check_eq("beat_err", err, e.err);
        end
        beats_seen++;
    endtask

    // Monitor: AR fields against the scoreboard head, R beats against the beat queue
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.m_axi_arvalid) begin
                    if (exp_ar.size() == 0) begin
                        check_eq("ar_pending", 128'(exp_ar.size()), 1);
                    end else begin
                        check_eq("araddr", bus.m_axi_araddr, exp_ar[0].addr);
                        check_eq("arlen", bus.m_axi_arlen, exp_ar[0].len);
                        check_eq("arid", bus.m_axi_arid, exp_ar[0].id);
                        check_eq("arsize", bus.m_axi_arsize, 3'd4);
                        check_eq("arburst", bus.m_axi_arburst, 2'b01);
                        if (bus.m_axi_arready) void'(exp_ar.pop_front());
                    end
                end
                if (bus.rd0_valid) begin
                    check_eq("rready_mirror0", bus.m_axi_rready, bus.rd0_ready);
                    if (bus.rd0_ready) check_beat(1'b0, bus.rd0_data, bus.rd0_last, bus.rd0_err);
                end
                if (bus.rd1_valid) begin
                    check_eq("rready_mirror1", bus.m_axi_rready, bus.rd1_ready);
                    if (bus.rd1_ready) check_beat(1'b1, bus.rd1_data, bus.rd1_last, bus.rd1_err);
                end
            end
        end
    end

    // Port 0 beat acceptance: steady or toggling every cycle
    initial begin
        bus.rd0_ready = 1'b1;
        bus.rd1_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.rd0_ready = rd_toggle ? ~bus.rd0_ready : 1'b1;
        end
    end

    task automatic serve_burst();
        logic [27:0] a;
        logic [7:0]  l;
        logic        id;
        logic        hs;
        int          n;
        int          i;
        int          guard;
        if (ar_stall > 0) bus.m_axi_arready = 1'b0;
        for (int s = 0; s < ar_stall; s++) begin
            check_eq("ar_hold_valid", bus.m_axi_arvalid, 1'b1);
            @(posedge clk);
            #1;
        end
        bus.m_axi_arready = 1'b1;
        a  = bus.m_axi_araddr;
        l  = bus.m_axi_arlen;
        id = bus.m_axi_arid;
        @(posedge clk);
        #1;
        bus.m_axi_arready = ar_idle_ready;
        n = (last_at >= 0) ? last_at : int'(l);
        i = 0;
        guard = 0;
        while (i <= n) begin
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = beat_data(a, i);
            bus.m_axi_rlast  = (i == n);
            bus.m_axi_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            bus.m_axi_rid    = id;
            @(negedge clk);
            hs = bus.m_axi_rready;
            @(posedge clk);
            #1;
            if (!rst_n) break;
            if (hs) i++;
            guard++;
            if (guard > 2000) begin
                check_eq("slave_timeout", 128'(guard), 0);
                break;
            end
        end
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        bus.m_axi_rresp  = 2'b00;
    endtask

    // DDR3 controller model
    initial begin
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rdata   = '0;
        bus.m_axi_rresp   = 2'b00;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rid     = 1'b0;
        forever begin
            bus.m_axi_arready = ar_idle_ready;
            @(posedge clk);
            #1;
            if (rst_n && bus.m_axi_arvalid) serve_burst();
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int l0;
        int l1;
        int base;
        int n;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_len   = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_len   = '0;
        rst_n = 1'b1;
        #2;
        apply_reset();

        // Single request, arready already high
        base = beats_seen;
        expect_burst(1'b0, 28'h000_1000, 8'd3);
        request(1'b0, 28'h000_1000, 8'd3, 1'b0, lat);
        check_eq("t1_req_lat", 128'(lat), 2);
        wait_drain();
        check_eq("t1_beats", 128'(beats_seen - base), 4);

        // Both ports held for four bursts: grants 0,1,0,1
        apply_reset();
        expect_burst(1'b0, 28'h010_0000, 8'd1);
        expect_burst(1'b1, 28'h020_0000, 8'd2);
        expect_burst(1'b0, 28'h010_0100, 8'd1);
        expect_burst(1'b1, 28'h020_0100, 8'd3);
        fork
            begin
                request(1'b0, 28'h010_0000, 8'd1, 1'b1, l0);
                request(1'b0, 28'h010_0100, 8'd1, 1'b0, l0);
            end
            begin
                request(1'b1, 28'h020_0000, 8'd2, 1'b1, l1);
                request(1'b1, 28'h020_0100, 8'd3, 1'b0, l1);
            end
        join
        wait_drain();

        // AR backpressure for 5 cycles, rd0_ready toggling, len 7
        ar_idle_ready = 1'b0;
        ar_stall = 5;
        rd_toggle = 1'b1;
        @(posedge clk);
        #1;
        base = beats_seen;
        expect_burst(1'b0, 28'h000_3040, 8'd7);
        request(1'b0, 28'h000_3040, 8'd7, 1'b0, lat);
        wait_drain();
        check_eq("t3_beats", 128'(beats_seen - base), 8);
        rd_toggle = 1'b0;
        ar_stall = 0;
        ar_idle_ready = 1'b1;
        @(posedge clk);
        #1;

        // SLVERR on beat 2 of 4 on port 1
        err_beat = 1;
        expect_burst(1'b1, 28'h000_4000, 8'd3);
        request(1'b1, 28'h000_4000, 8'd3, 1'b0, lat);
        wait_drain();
        err_beat = -1;
        check_eq("t4_err_last", bus.err_last, 1'b0);

        // Burst ending exactly at 4 KB is legal; one beat past it is flagged
        expect_burst(1'b0, 28'h000_0FE0, 8'd1);
        request(1'b0, 28'h000_0FE0, 8'd1, 1'b0, lat);
        wait_drain();
        check_eq("t5_no_4k", bus.err_4k, 1'b0);
        expect_burst(1'b0, 28'h000_0FF0, 8'd1);
        request(1'b0, 28'h000_0FF0, 8'd1, 1'b0, lat);
        wait_drain();
        check_eq("t5_err_4k", bus.err_4k, 1'b1);
        check_eq("t5_err_last", bus.err_last, 1'b0);

        // Early RLAST on beat 3 of a len 3 burst
        last_at = 2;
        expect_burst(1'b0, 28'h000_5000, 8'd3);
        request(1'b0, 28'h000_5000, 8'd3, 1'b0, lat);
        wait_drain();
        last_at = -1;
        check_eq("t6_err_last", bus.err_last, 1'b1);
        expect_burst(1'b1, 28'h000_6000, 8'd0);
        request(1'b1, 28'h000_6000, 8'd0, 1'b0, lat);
        wait_drain();
        check_eq("t6_keep_4k", bus.err_4k, 1'b1);
        check_eq("t6_keep_last", bus.err_last, 1'b1);

        // Reset clears the sticky flags; then reset again during beat 2 of 8
        apply_reset();
        base = beats_seen;
        expect_burst(1'b0, 28'h000_7000, 8'd7);
        request(1'b0, 28'h000_7000, 8'd7, 1'b0, lat);
        n = 0;
        while (beats_seen < base + 2 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("t7_reach_beat2", 128'(beats_seen - base), 2);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid");
        exp_beats.delete();
        exp_ar.delete();
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        expect_burst(1'b1, 28'h000_8000, 8'd1);
        request(1'b1, 28'h000_8000, 8'd1, 1'b0, lat);
        check_eq("t7_req1_lat", 128'(lat), 2);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
